// File: rtl/adpll_pkg.sv
`default_nettype none
// ============================================================================
// Module      : adpll_pkg (package)
// Description : Constants and helpers shared by the ADPLL blocks: the K-counter,
//               the ID counter and the DCO divider.
//               K_MIN            smallest legal modulus
//               DEF_WIDTH        default counter / modulus width
//               DEF_K_DEFAULT    default modulus loaded at reset
//               clamp_k(k)       returns max(k, K_MIN)
// Revision    : 1.0  initial release
// ============================================================================
package adpll_pkg;

    localparam int unsigned K_MIN         = 2;
    localparam int          DEF_WIDTH     = 8;
    localparam int          DEF_K_DEFAULT = 16;

    // A modulus of 0 or 1 would make the wrap compare (k-1) degenerate, so
    // anything below K_MIN is raised to K_MIN.
    function automatic int unsigned clamp_k(input int unsigned k);
        return (k < K_MIN) ? K_MIN : k;
    endfunction

endpackage : adpll_pkg
`default_nettype wire

// File: rtl/mod_k_stage.sv
`default_nettype none
// ============================================================================
// Module      : mod_k_stage
// Description : One modulo-K counter. Counts 0..k-1 on each edge with inc=1
//               and emits a registered one-cycle wrap pulse in the cycle after
//               the edge on which it wrapped k-1 -> 0.
// Ports       : clk   in   1      rising-edge clock
//               rst   in   1      synchronous active-high reset
//               inc   in   1      advance the count this edge
//               clr   in   1      clear the count (beats inc)
//               k     in   WIDTH  modulus in force (>= 2)
//               cnt   out  WIDTH  current count
//               wrap  out  1      one-cycle pulse after a wrap
// Revision    : 1.0  initial release
// ============================================================================
module mod_k_stage
    import adpll_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    input  logic [WIDTH-1:0] k,
    output logic [WIDTH-1:0] cnt,
    output logic             wrap
);

    logic [WIDTH-1:0] r_cnt;
    logic             r_wrap;
    logic             w_last;

    // The count never reaches k, so equality with k-1 is the only wrap point.
    assign w_last = (r_cnt == (k - WIDTH'(1)));

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_cnt  <= '0;
            r_wrap <= 1'b0;
        end else if (inc) begin
            r_cnt  <= w_last ? '0 : (r_cnt + WIDTH'(1));
            r_wrap <= w_last;
        end else begin
            r_wrap <= 1'b0;
        end
    end

    assign cnt  = r_cnt;
    assign wrap = r_wrap;

endmodule : mod_k_stage
`default_nettype wire

// File: rtl/k_counter_updn.sv
`default_nettype none
// ============================================================================
// Module      : k_counter_updn
// Description : ADPLL K-counter (loop filter). An up and a down modulo-K
//               counter advance on enabled clocks according to the phase
//               detector error dn_up; each wrap yields a one-cycle carry or
//               borrow pulse. The modulus can be reloaded at run time.
// Ports       : clk     in   1      rising-edge clock
//               rst     in   1      synchronous active-high reset
//               en      in   1      count enable
//               dn_up   in   1      0 = up counter, 1 = down counter
//               k_mod   in   WIDTH  new modulus, taken when k_load=1
//               k_load  in   1      load modulus (values 0/1 clamp to 2)
//               carry   out  1      pulse after up counter wrap
//               borrow  out  1      pulse after down counter wrap
//               up_cnt  out  WIDTH  up counter value
//               dn_cnt  out  WIDTH  down counter value
//               k_cur   out  WIDTH  modulus in force
//               up_sq   out  1      (K_SQUARE_OUT_EN only) up_cnt >= k_cur/2
//               dn_sq   out  1      (K_SQUARE_OUT_EN only) dn_cnt >= k_cur/2
// Config      : define K_SQUARE_OUT_EN to add the up_sq/dn_sq square outputs.
// Revision    : 1.0  initial release
// ============================================================================
module k_counter_updn
    import adpll_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int K_DEFAULT = DEF_K_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             dn_up,
    input  logic [WIDTH-1:0] k_mod,
    input  logic             k_load,
    output logic             carry,
    output logic             borrow,
    output logic [WIDTH-1:0] up_cnt,
    output logic [WIDTH-1:0] dn_cnt,
`ifdef K_SQUARE_OUT_EN
    output logic             up_sq,
    output logic             dn_sq,
`endif
    output logic [WIDTH-1:0] k_cur
);

    localparam logic [WIDTH-1:0] c_k_reset = WIDTH'(K_DEFAULT);

    logic [WIDTH-1:0] r_k_cur;
    logic [WIDTH-1:0] w_k_load_val;
    logic             w_up_inc;
    logic             w_dn_inc;
    logic [WIDTH-1:0] w_up_cnt;
    logic [WIDTH-1:0] w_dn_cnt;
    logic             w_up_wrap;
    logic             w_dn_wrap;

    assign w_k_load_val = WIDTH'(clamp_k(32'(k_mod)));

    // A load clears both counters on the same edge, so it must also suppress
    // counting; otherwise a stale wrap could fire against the new modulus.
    assign w_up_inc = en && !dn_up && !k_load;
    assign w_dn_inc = en &&  dn_up && !k_load;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_k_cur <= c_k_reset;
        end else if (k_load) begin
            r_k_cur <= w_k_load_val;
        end
    end

    mod_k_stage #(
        .WIDTH (WIDTH)
    ) u_up_stage (
        .clk  (clk),
        .rst  (rst),
        .inc  (w_up_inc),
        .clr  (k_load),
        .k    (r_k_cur),
        .cnt  (w_up_cnt),
        .wrap (w_up_wrap)
    );

    mod_k_stage #(
        .WIDTH (WIDTH)
    ) u_dn_stage (
        .clk  (clk),
        .rst  (rst),
        .inc  (w_dn_inc),
        .clr  (k_load),
        .k    (r_k_cur),
        .cnt  (w_dn_cnt),
        .wrap (w_dn_wrap)
    );

`ifdef K_SQUARE_OUT_EN
    logic             r_up_sq;
    logic             r_dn_sq;
    logic [WIDTH-1:0] w_half_k;

    assign w_half_k = r_k_cur >> 1;

    // Registered compare of the present count: the square edge trails the
    // count by one clock, which keeps the duty at ~50% for a DCO reference.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_up_sq <= 1'b0;
            r_dn_sq <= 1'b0;
        end else begin
            r_up_sq <= (w_up_cnt >= w_half_k);
            r_dn_sq <= (w_dn_cnt >= w_half_k);
        end
    end

    assign up_sq = r_up_sq;
    assign dn_sq = r_dn_sq;
`endif

    assign carry  = w_up_wrap;
    assign borrow = w_dn_wrap;
    assign up_cnt = w_up_cnt;
    assign dn_cnt = w_dn_cnt;
    assign k_cur  = r_k_cur;

endmodule : k_counter_updn
`default_nettype wire

// File: tb/tb_k_counter_updn.sv
`default_nettype none
// ============================================================================
// Module      : tb_k_counter_updn
// Description : Self-checking bench for k_counter_updn. A behavioural model
//               (integer counts taken modulo K) predicts every output; a
//               negedge compare process checks the DUT each cycle. Directed
//               scenarios pin pulse counts to hand-computed literals, then a
//               randomized phase exercises mixed enable/direction/load/reset.
// Revision    : 1.0  initial release
// ============================================================================
module tb_k_counter_updn;

    localparam int WIDTH     = 8;
    localparam int K_DEFAULT = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             en = 1'b0;
    logic             dn_up = 1'b0;
    logic [WIDTH-1:0] k_mod = '0;
    logic             k_load = 1'b0;
    logic             carry;
    logic             borrow;
    logic [WIDTH-1:0] up_cnt;
    logic [WIDTH-1:0] dn_cnt;
    logic [WIDTH-1:0] k_cur;
`ifdef K_SQUARE_OUT_EN
    logic             up_sq;
    logic             dn_sq;
`endif

    k_counter_updn #(
        .WIDTH     (WIDTH),
        .K_DEFAULT (K_DEFAULT)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .dn_up  (dn_up),
        .k_mod  (k_mod),
        .k_load (k_load),
        .carry  (carry),
        .borrow (borrow),
        .up_cnt (up_cnt),
        .dn_cnt (dn_cnt),
`ifdef K_SQUARE_OUT_EN
        .up_sq  (up_sq),
        .dn_sq  (dn_sq),
`endif
        .k_cur  (k_cur)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model state
    int m_up = 0;
    int m_dn = 0;
    int m_k  = K_DEFAULT;
    int m_carry = 0;
    int m_borrow = 0;

    bit chk_on = 1'b0;
    int n_carry_seen = 0;
    int n_borrow_seen = 0;
    int n_sq_high = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model of one clock edge, written from the counter rules directly.
    task automatic model_edge(input bit r, input bit e, input bit d,
                              input bit ld, input int km);
        if (r) begin
            m_up = 0; m_dn = 0; m_k = K_DEFAULT; m_carry = 0; m_borrow = 0;
        end else if (ld) begin
            m_k = (km < 2) ? 2 : km;
            m_up = 0; m_dn = 0; m_carry = 0; m_borrow = 0;
        end else if (e && !d) begin
            m_carry  = ((m_up + 1) == m_k) ? 1 : 0;
            m_up     = (m_up + 1) % m_k;
            m_borrow = 0;
        end else if (e && d) begin
            m_borrow = ((m_dn + 1) == m_k) ? 1 : 0;
            m_dn     = (m_dn + 1) % m_k;
            m_carry  = 0;
        end else begin
            m_carry = 0; m_borrow = 0;
        end
    endtask

    // Drive one cycle: inputs settle before the edge, model follows the edge.
    task automatic step(input bit r, input bit e, input bit d,
                        input bit ld, input int km);
        rst = r; en = e; dn_up = d; k_load = ld; k_mod = WIDTH'(km);
        @(posedge clk);
        model_edge(r, e, d, ld, km);
        #1;
    endtask

    task automatic run(input int n, input bit d);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, d, 1'b0, 0);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 1'b0, 0);
    endtask

    task automatic clear_seen();
        n_carry_seen = 0; n_borrow_seen = 0; n_sq_high = 0;
    endtask

    // Single compare process: outputs checked each cycle at the falling edge.
    always @(negedge clk) begin
        if (chk_on) begin
            chk("carry",  int'(carry),  m_carry);
            chk("borrow", int'(borrow), m_borrow);
            chk("up_cnt", int'(up_cnt), m_up);
            chk("dn_cnt", int'(dn_cnt), m_dn);
            chk("k_cur",  int'(k_cur),  m_k);
            if (carry && borrow) chk("carry_and_borrow", 1, 0);
            if (carry)  n_carry_seen++;
            if (borrow) n_borrow_seen++;
`ifdef K_SQUARE_OUT_EN
            if (up_sq) n_sq_high++;
`endif
        end
    end

    initial begin
        // Initial reset and reset-state check
        step(1'b1, 1'b0, 1'b0, 1'b0, 0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 0);
        chk("reset_k_cur", int'(k_cur), 16);
        chk("reset_up_cnt", int'(up_cnt), 0);
        chk("reset_carry", int'(carry), 0);
        chk_on = 1'b1;

        // Scenario 1: K=16, 32 up edges -> 2 carries, no borrow
        step(1'b0, 1'b0, 1'b0, 1'b0, 0);
        clear_seen();
        run(32, 1'b0);
        idle();
        chk("s1_carries", n_carry_seen, 2);
        chk("s1_borrows", n_borrow_seen, 0);

        // Scenario 2: K=5, 15 down edges -> 3 borrows, up_cnt stays 0
        step(1'b0, 1'b0, 1'b0, 1'b1, 5);
        clear_seen();
        run(15, 1'b1);
        idle();
        chk("s2_borrows", n_borrow_seen, 3);
        chk("s2_up_cnt", int'(up_cnt), 0);

        // Scenario 3: up 3, down 2, up 2 with K=5
        step(1'b0, 1'b0, 1'b0, 1'b1, 5);
        clear_seen();
        run(3, 1'b0);
        run(2, 1'b1);
        run(2, 1'b0);
        idle();
        chk("s3_carries", n_carry_seen, 1);
        chk("s3_dn_cnt", int'(dn_cnt), 2);
        chk("s3_model_dn", m_dn, 2);

        // Scenario 4: load k_mod=1 together with en=1 -> K=2, no pulse
        run(1, 1'b0);
        clear_seen();
        step(1'b0, 1'b1, 1'b0, 1'b1, 1);
        chk("s4_k_cur", int'(k_cur), 2);
        chk("s4_up_cnt", int'(up_cnt), 0);
        idle();
        chk("s4_no_pulse", n_carry_seen, 0);
        run(4, 1'b0);
        idle();
        chk("s4_carries", n_carry_seen, 2);

        // Scenario 5: reset when up_cnt=K-1 with en=1 discards the wrap
        step(1'b0, 1'b0, 1'b0, 1'b1, 7);
        run(6, 1'b0);
        chk("s5_up_at_k_minus_1", int'(up_cnt), 6);
        clear_seen();
        step(1'b1, 1'b1, 1'b0, 1'b0, 0);
        idle();
        chk("s5_no_carry", n_carry_seen, 0);
        chk("s5_up_cnt", int'(up_cnt), 0);
        chk("s5_k_cur", int'(k_cur), 16);

`ifdef K_SQUARE_OUT_EN
        // Scenario 6: K=8 square output is high for half of 16 counts
        step(1'b0, 1'b0, 1'b0, 1'b1, 8);
        idle();
        clear_seen();
        run(16, 1'b0);
        idle();
        chk("s6_sq_high", n_sq_high, 8);
`endif

        // Randomized phase
        for (int i = 0; i < 3000; i++) begin
            automatic bit r  = ($urandom_range(0, 199) == 0);
            automatic bit ld = ($urandom_range(0, 59) == 0);
            automatic bit e  = ($urandom_range(0, 9) < 7);
            automatic bit d  = $urandom_range(0, 1) != 0;
            automatic int km = ($urandom_range(0, 3) == 0) ?
                               int'($urandom_range(0, 255)) :
                               int'($urandom_range(0, 12));
            step(r, e, d, ld, km);
        end
        idle();
        idle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Absolute time bound so the run always ends on its own.
    initial begin
        #500000;
        $display("FAIL timeout: got no finish expected finish by 500000");
        n_errors++;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1);
    end

endmodule : tb_k_counter_updn
`default_nettype wire
